axis_frame_tagger: RTL and testbench
====================================

# axis_frame_tagger

Output-side framing stage for the super-resolution pipeline. Consumes the raw 24-bit RGB pixel stream produced by the upscaling core and emits a fully tagged AXI4-Stream (tuser = start of frame, tlast = end of line, tkeep/tstrb all-ones) toward the video output DMA. Tracks column and row position with counters, decouples backpressure through a 2-entry skid buffer, and reports frame completion.

## Interface
- AXIS_DATA_WIDTH, 24: pixel / tdata width in bits; must be a multiple of 8.
- IMG_WIDTH, 3840: pixels per output line, ≥2.
- IMG_HEIGHT, 2160: lines per output frame, ≥1.
- aclk  in  1  single clock; all logic on rising edge.
- arst  in  1  asynchronous, active-high reset.
- s_pix_valid  in  1  upstream pixel valid.
- s_pix_ready  out  1  block can accept a pixel.
- s_pix_data  in  AXIS_DATA_WIDTH  RGB pixel.
- s_pix_sof  in  1  upstream start-of-frame marker; used only with SOF_CHECK_EN.
- m_axis_tvalid  out  1  output beat valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tdata  out  AXIS_DATA_WIDTH  pixel.
- m_axis_tstrb / m_axis_tkeep  out  AXIS_DATA_WIDTH/8 each  constant all-ones while tvalid, 0 otherwise.
- m_axis_tlast  out  1  last pixel of a line.
- m_axis_tuser  out  1  first pixel of a frame.
- m_axis_tid / m_axis_tdest  out  1 each  tied 0.
- frame_done  out  1  one-cycle pulse when the frame's final beat transfers on the master side.
- err_sof  out  1  sticky framing error; 0 without SOF_CHECK_EN.

## Operation
- Input transfer: s_pix_valid && s_pix_ready. Output transfer: m_axis_tvalid && m_axis_tready.
- Counters col (0..IMG_WIDTH-1) and row (0..IMG_HEIGHT-1), width $clog2 of each bound, advance on every input transfer.
- Tags computed at input acceptance and stored with the pixel: tlast = (col==IMG_WIDTH-1); tuser = (col==0 && row==0).
- Wrap: col==IMG_WIDTH-1 → col=0, row+1; additionally row==IMG_HEIGHT-1 → row=0 (next pixel starts new frame).
- Skid buffer: 2 entries {data, tlast, tuser}. Entry 0 drives the master outputs. s_pix_ready = (occupancy < 2), registered.
- Simultaneous input and output transfer with occupancy 1 or 2: occupancy unchanged, order preserved.
- frame_done asserts the cycle after an output transfer with tlast && (beat is last line of frame), tracked by an output-side last-line flag carried in the entry.
- Skid buffer never drops or duplicates a beat; m_axis_* stable while tvalid && !tready (AXI-Stream rule).

## Timing
- Reset (arst high, any time): s_pix_ready=0, m_axis_tvalid=0, tdata/tlast/tuser=0, frame_done=0, err_sof=0, col=row=0, buffer empty. Mid-frame reset discards all buffered pixels.
- First rising edge after arst deasserts: s_pix_ready → 1.
- Latency: pixel accepted at edge N appears on m_axis at edge N+1 when buffer was empty.
- Throughput: 1 pixel/cycle sustained with m_axis_tready held high.
- s_pix_ready falls the cycle after the second entry fills; rises the cycle after an output transfer frees an entry.

## Configuration
- SOF_CHECK_EN defined: on an accepted pixel with s_pix_sof=1 while (col,row)≠(0,0), set err_sof and resync: that pixel is tagged tuser=1 as (0,0) and counters continue from (1,0). Pixel at (0,0) with s_pix_sof=0 sets err_sof, no resync. err_sof clears only on reset.
- Undefined: s_pix_sof ignored, err_sof tied 0, no resync logic.

## Structure
- Package axis_frame_pkg: AXIS_DATA_WIDTH default constant, pixel_t typedef, beat_t struct {pixel_t data; logic last; logic user; logic frame_end}.
- Sub-module axis_skid_buffer (2-entry, parameterised on beat_t width) instantiated once; counters and tagging stay in the top.

## Test plan
- IMG_WIDTH=4, IMG_HEIGHT=2, tready=1, 8 pixels 0x000001..0x000008 → beats in order, tuser on 0x000001 only, tlast on 0x000004 and 0x000008, frame_done one cycle after beat 8.
- Same stream, tready low cycles 2–5 → s_pix_ready low after 2 buffered, no loss/duplication, outputs stable while stalled.
- Two back-to-back frames → second frame's first pixel carries tuser, counters wrapped, two frame_done pulses.
- arst pulsed after pixel 3 accepted → all outputs 0 immediately, next frame restarts at (0,0) with tuser.
- SOF_CHECK_EN, s_pix_sof=1 on pixel 3 → err_sof=1, pixel 3 tagged tuser, tlast on pixel 6.
- Random valid/ready toggling, 1000 frames of 4x2 → output equals input sequence, tag pattern exact.

Source files
------------

// File: rtl/axis_frame_pkg.sv
// Shared types for the output framing stage: default pixel width, the pixel
// type and the tagged beat carried through the skid buffer.
package axis_frame_pkg;

    localparam int unsigned DEF_AXIS_DATA_WIDTH = 24;

    typedef logic [DEF_AXIS_DATA_WIDTH-1:0] pixel_t;

    // frame_end marks a beat that belongs to the last line of the frame.
    typedef struct packed {
        pixel_t data;
        logic   last;
        logic   user;
        logic   frame_end;
    } beat_t;

    localparam int unsigned BEAT_WIDTH = $bits(beat_t);

    // Counter width for a 0..bound-1 range, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned bound);
        return (bound > 1) ? $clog2(bound) : 1;
    endfunction

endpackage

// File: rtl/axis_frame_tagger_if.sv
// Pixel-in / AXI4-Stream-out bundle of the frame tagger. The master modport is
// the tagger itself (drives the stream outward), slave is the environment.
interface axis_frame_tagger_if #(
    parameter int unsigned AXIS_DATA_WIDTH = 24
);
    localparam int unsigned KEEP_W = AXIS_DATA_WIDTH / 8;

    logic                       s_pix_valid;
    logic                       s_pix_ready;
    logic [AXIS_DATA_WIDTH-1:0] s_pix_data;
    logic                       s_pix_sof;

    logic                       m_axis_tvalid;
    logic                       m_axis_tready;
    logic [AXIS_DATA_WIDTH-1:0] m_axis_tdata;
    logic [KEEP_W-1:0]          m_axis_tstrb;
    logic [KEEP_W-1:0]          m_axis_tkeep;
    logic                       m_axis_tlast;
    logic                       m_axis_tuser;
    logic                       m_axis_tid;
    logic                       m_axis_tdest;

    modport master (
        input  s_pix_valid, s_pix_data, s_pix_sof, m_axis_tready,
        output s_pix_ready, m_axis_tvalid, m_axis_tdata, m_axis_tstrb, m_axis_tkeep,
               m_axis_tlast, m_axis_tuser, m_axis_tid, m_axis_tdest
    );

    modport slave (
        output s_pix_valid, s_pix_data, s_pix_sof, m_axis_tready,
        input  s_pix_ready, m_axis_tvalid, m_axis_tdata, m_axis_tstrb, m_axis_tkeep,
               m_axis_tlast, m_axis_tuser, m_axis_tid, m_axis_tdest
    );

endinterface

// File: rtl/axis_skid_buffer.sv
// Two-entry skid buffer. Entry 0 always holds the head beat and drives the
// output directly; in_ready is registered and low only while both entries are
// occupied, so the upstream path has no combinational dependence on out_ready.
module axis_skid_buffer
    import axis_frame_pkg::*;
#(
    parameter int unsigned WIDTH = BEAT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic [WIDTH-1:0] ent0_q, ent0_d;
    logic [WIDTH-1:0] ent1_q, ent1_d;
    logic [1:0]       occ_q, occ_d;
    logic             ready_q;
    logic             push, pop;

    assign push = in_valid && ready_q;
    assign pop  = (occ_q != 2'd0) && out_ready;

    // Next entry contents and occupancy; push with a full buffer cannot occur.
    always_comb begin
        ent0_d = ent0_q;
        ent1_d = ent1_q;
        occ_d  = occ_q;
        case ({push, pop})
            2'b10: begin
                if (occ_q == 2'd0) ent0_d = in_data;
                else               ent1_d = in_data;
                occ_d = occ_q + 2'd1;
            end
            2'b01: begin
                ent0_d = ent1_q;
                occ_d  = occ_q - 2'd1;
            end
            2'b11: begin
                if (occ_q == 2'd1) begin
                    ent0_d = in_data;
                end else begin
                    ent0_d = ent1_q;
                    ent1_d = in_data;
                end
            end
            default: ;
        endcase
    end

    // Entry, occupancy and registered-ready state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ent0_q  <= '0;
            ent1_q  <= '0;
            occ_q   <= 2'd0;
            ready_q <= 1'b0;
        end else begin
            ent0_q  <= ent0_d;
            ent1_q  <= ent1_d;
            occ_q   <= occ_d;
            ready_q <= (occ_d != 2'd2);
        end
    end

    assign in_ready  = ready_q;
    assign out_valid = (occ_q != 2'd0);
    assign out_data  = ent0_q;

endmodule

// File: rtl/axis_frame_tagger.sv
// Output framing stage: tags the raw pixel stream with tuser (start of frame)
// and tlast (end of line), buffers it through a 2-entry skid buffer and pulses
// frame_done when the last beat of a frame leaves.
// Optional feature macro: SOF_CHECK_EN -- checks s_pix_sof against the internal
// position, raises sticky err_sof and resyncs on an unexpected start of frame.
module axis_frame_tagger
    import axis_frame_pkg::*;
#(
    parameter int unsigned AXIS_DATA_WIDTH = DEF_AXIS_DATA_WIDTH,
    parameter int unsigned IMG_WIDTH       = 3840,
    parameter int unsigned IMG_HEIGHT      = 2160
) (
    input  logic                aclk,
    input  logic                arst,
    axis_frame_tagger_if.master bus,
    output logic                frame_done,
    output logic                err_sof
);

    localparam int unsigned COL_W  = cnt_width(IMG_WIDTH);
    localparam int unsigned ROW_W  = cnt_width(IMG_HEIGHT);
    localparam int unsigned KEEP_W = AXIS_DATA_WIDTH / 8;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

    // Same layout as beat_t, but with the data field following the parameter.
    typedef struct packed {
        logic [AXIS_DATA_WIDTH-1:0] data;
        logic                       last;
        logic                       user;
        logic                       frame_end;
    } tag_beat_t;

    logic [COL_W-1:0] col_q, col_d, eff_col;
    logic [ROW_W-1:0] row_q, row_d, eff_row;
    logic             in_xfer, out_xfer;
    logic             out_valid;
    logic             frame_done_q;
    tag_beat_t        in_beat, out_beat;

    assign in_xfer  = bus.s_pix_valid && bus.s_pix_ready;
    assign out_xfer = out_valid && bus.m_axis_tready;

`ifdef SOF_CHECK_EN
    logic at_origin, resync, err_q;

    assign at_origin = (col_q == '0) && (row_q == '0);
    assign resync    = bus.s_pix_sof && !at_origin;
    // A resynced pixel is treated as position (0,0).
    assign eff_col   = resync ? '0 : col_q;
    assign eff_row   = resync ? '0 : row_q;

    // Sticky error: SOF seen mid-frame, or missing at the frame's first pixel.
    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            err_q <= 1'b0;
        end else if (in_xfer && (resync || (at_origin && !bus.s_pix_sof))) begin
            err_q <= 1'b1;
        end
    end

    assign err_sof = err_q;
`else
    assign eff_col = col_q;
    assign eff_row = row_q;
    assign err_sof = 1'b0;
`endif

    // Tags for the incoming pixel and the position of the following pixel.
    always_comb begin
        in_beat.data      = bus.s_pix_data;
        in_beat.last      = (eff_col == COL_LAST);
        in_beat.user      = (eff_col == '0) && (eff_row == '0);
        in_beat.frame_end = (eff_row == ROW_LAST);
        if (eff_col == COL_LAST) begin
            col_d = '0;
            row_d = (eff_row == ROW_LAST) ? '0 : eff_row + ROW_W'(1);
        end else begin
            col_d = eff_col + COL_W'(1);
            row_d = eff_row;
        end
    end

    // Position counters advance on every accepted pixel.
    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            col_q <= '0;
            row_q <= '0;
        end else if (in_xfer) begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    // One-cycle pulse after the final beat of a frame transfers downstream.
    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= out_xfer && out_beat.last && out_beat.frame_end;
        end
    end

    axis_skid_buffer #(
        .WIDTH ($bits(tag_beat_t))
    ) u_skid (
        .clk       (aclk),
        .rst       (arst),
        .in_valid  (bus.s_pix_valid),
        .in_ready  (bus.s_pix_ready),
        .in_data   (in_beat),
        .out_valid (out_valid),
        .out_ready (bus.m_axis_tready),
        .out_data  (out_beat)
    );

    assign bus.m_axis_tvalid = out_valid;
    assign bus.m_axis_tdata  = out_beat.data;
    assign bus.m_axis_tlast  = out_beat.last;
    assign bus.m_axis_tuser  = out_beat.user;
    assign bus.m_axis_tkeep  = {KEEP_W{out_valid}};
    assign bus.m_axis_tstrb  = {KEEP_W{out_valid}};
    assign bus.m_axis_tid    = 1'b0;
    assign bus.m_axis_tdest  = 1'b0;
    assign frame_done        = frame_done_q;

endmodule

// File: tb/tb_axis_frame_tagger.sv
// Self-checking bench for axis_frame_tagger with a 4x2 frame.
module tb_axis_frame_tagger;

    localparam int unsigned DW = 24;
    localparam int unsigned W  = 4;
    localparam int unsigned H  = 2;
    localparam int unsigned NP = W * H;

    logic aclk = 1'b0;
    logic arst = 1'b0;
    logic frame_done;
    logic err_sof;

    int checks = 0;
    int errors = 0;

    axis_frame_tagger_if #(.AXIS_DATA_WIDTH(DW)) bus ();

    axis_frame_tagger #(
        .AXIS_DATA_WIDTH (DW),
        .IMG_WIDTH       (W),
        .IMG_HEIGHT      (H)
    ) dut (
        .aclk       (aclk),
        .arst       (arst),
        .bus        (bus),
        .frame_done (frame_done),
        .err_sof    (err_sof)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic        v;
        logic [23:0] d;
        logic        tr;
        logic        e_tv;
        logic [23:0] e_d;
        logic        e_last;
        logic        e_user;
        logic        e_done;
        logic        e_rdy;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [23:0] pix(input int k);
        return 24'((k * 7919 + 13) ^ (k << 9));
    endfunction

    task automatic add_vec(input logic v, input logic [23:0] d, input logic tr,
                           input logic e_tv, input logic [23:0] e_d, input logic e_last,
                           input logic e_user, input logic e_done, input logic e_rdy);
        vec_t x;
        x.v = v; x.d = d; x.tr = tr; x.e_tv = e_tv; x.e_d = e_d;
        x.e_last = e_last; x.e_user = e_user; x.e_done = e_done; x.e_rdy = e_rdy;
        tbl.push_back(x);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_s_ready"}, bus.s_pix_ready, 0);
        check({tag, "_tvalid"}, bus.m_axis_tvalid, 0);
        check({tag, "_tdata"}, bus.m_axis_tdata, 0);
        check({tag, "_tlast"}, bus.m_axis_tlast, 0);
        check({tag, "_tuser"}, bus.m_axis_tuser, 0);
        check({tag, "_tkeep_tstrb"}, {bus.m_axis_tkeep, bus.m_axis_tstrb}, 0);
        check({tag, "_done"}, frame_done, 0);
        check({tag, "_err"}, err_sof, 0);
    endtask

    // Called at a negedge; returns at the negedge where s_pix_ready is first high.
    task automatic apply_reset(input string tag);
        bus.s_pix_valid   = 1'b0;
        bus.s_pix_data    = '0;
        bus.s_pix_sof     = 1'b0;
        bus.m_axis_tready = 1'b0;
        arst = 1'b1;
        #1;
        check_reset_outputs(tag);
        repeat (2) @(negedge aclk);
        arst = 1'b0;
        check({tag, "_ready_held_low"}, bus.s_pix_ready, 0);
        @(negedge aclk);
        check({tag, "_ready_after_release"}, bus.s_pix_ready, 1);
    endtask

    // Each record: compare outputs at this negedge, then drive the next inputs.
    task automatic run_table(input string tag);
        foreach (tbl[i]) begin
            check($sformatf("%s_%0d_s_ready", tag, i), bus.s_pix_ready, tbl[i].e_rdy);
            check($sformatf("%s_%0d_tvalid", tag, i), bus.m_axis_tvalid, tbl[i].e_tv);
            check($sformatf("%s_%0d_done", tag, i), frame_done, tbl[i].e_done);
            if (tbl[i].e_tv) begin
                check($sformatf("%s_%0d_beat", tag, i),
                      {bus.m_axis_tdata, bus.m_axis_tlast, bus.m_axis_tuser, bus.m_axis_tkeep},
                      {tbl[i].e_d, tbl[i].e_last, tbl[i].e_user, 3'b111});
            end else begin
                check($sformatf("%s_%0d_tkeep_idle", tag, i), bus.m_axis_tkeep, 0);
            end
            bus.s_pix_valid   = tbl[i].v;
            bus.s_pix_data    = tbl[i].d;
            bus.m_axis_tready = tbl[i].tr;
            @(negedge aclk);
        end
        tbl.delete();
    endtask

    // Random (or full-rate) stream of whole frames against an index-based model.
    task automatic run_stream(input string tag, input int frames, input int vpct,
                              input int rpct, output int cyc);
        int          n     = frames * NP;
        int          sent  = 0;
        int          rcvd  = 0;
        int          dones = 0;
        logic        acc   = 1'b0;
        logic        stall = 1'b0;
        logic        exp_done = 1'b0;
        logic [25:0] hold  = '0;
        cyc = 0;
        while ((rcvd < n || exp_done) && cyc < n * 20 + 50) begin
            check({tag, "_done"}, frame_done, exp_done);
            if (frame_done) dones++;
            if (stall) begin
                check({tag, "_stall_hold"},
                      {bus.m_axis_tvalid, bus.m_axis_tdata, bus.m_axis_tlast, bus.m_axis_tuser},
                      {1'b1, hold});
            end
            if (!bus.s_pix_valid || acc) begin
                if (sent < n && $urandom_range(99) < vpct) begin
                    bus.s_pix_valid = 1'b1;
                    bus.s_pix_data  = pix(sent);
                    bus.s_pix_sof   = (sent % NP == 0);
                end else begin
                    bus.s_pix_valid = 1'b0;
                end
            end
            bus.m_axis_tready = ($urandom_range(99) < rpct);
            acc = bus.s_pix_valid && bus.s_pix_ready;
            if (acc) sent++;
            exp_done = 1'b0;
            if (bus.m_axis_tvalid && bus.m_axis_tready) begin
                check({tag, "_beat"}, {bus.m_axis_tdata, bus.m_axis_tlast, bus.m_axis_tuser},
                      {pix(rcvd), rcvd % W == W - 1, rcvd % NP == 0});
                exp_done = (rcvd % NP == NP - 1);
                rcvd++;
            end
            stall = bus.m_axis_tvalid && !bus.m_axis_tready;
            hold  = {bus.m_axis_tdata, bus.m_axis_tlast, bus.m_axis_tuser};
            cyc++;
            @(negedge aclk);
        end
        check({tag, "_beats_received"}, rcvd, n);
        check({tag, "_frame_done_count"}, dones, frames);
        check({tag, "_err_sof"}, err_sof, 0);
        bus.s_pix_valid   = 1'b0;
        bus.m_axis_tready = 1'b0;
    endtask

    initial begin
        int          cyc;
        logic [5:0]  exp_user, exp_last, exp_err;

        bus.s_pix_valid   = 1'b0;
        bus.s_pix_data    = '0;
        bus.s_pix_sof     = 1'b0;
        bus.m_axis_tready = 1'b0;
        @(negedge aclk);

        // Single frame, tready high.
        apply_reset("rst0");
        add_vec(1, 24'h1, 1,  0, 24'h0, 0, 0, 0, 1);
        add_vec(1, 24'h2, 1,  1, 24'h1, 0, 1, 0, 1);
        add_vec(1, 24'h3, 1,  1, 24'h2, 0, 0, 0, 1);
        add_vec(1, 24'h4, 1,  1, 24'h3, 0, 0, 0, 1);
        add_vec(1, 24'h5, 1,  1, 24'h4, 1, 0, 0, 1);
        add_vec(1, 24'h6, 1,  1, 24'h5, 0, 0, 0, 1);
        add_vec(1, 24'h7, 1,  1, 24'h6, 0, 0, 0, 1);
        add_vec(1, 24'h8, 1,  1, 24'h7, 0, 0, 0, 1);
        add_vec(0, 24'h0, 1,  1, 24'h8, 1, 0, 0, 1);
        add_vec(0, 24'h0, 1,  0, 24'h0, 0, 0, 1, 1);
        add_vec(0, 24'h0, 1,  0, 24'h0, 0, 0, 0, 1);
        run_table("basic");

        // Same frame with tready low for cycles 2..5.
        apply_reset("rst1");
        add_vec(1, 24'h1, 1,  0, 24'h0, 0, 0, 0, 1);
        add_vec(1, 24'h2, 1,  1, 24'h1, 0, 1, 0, 1);
        add_vec(1, 24'h3, 0,  1, 24'h2, 0, 0, 0, 1);
        add_vec(1, 24'h4, 0,  1, 24'h2, 0, 0, 0, 0);
        add_vec(1, 24'h4, 0,  1, 24'h2, 0, 0, 0, 0);
        add_vec(1, 24'h4, 0,  1, 24'h2, 0, 0, 0, 0);
        add_vec(1, 24'h4, 1,  1, 24'h2, 0, 0, 0, 0);
        add_vec(1, 24'h4, 1,  1, 24'h3, 0, 0, 0, 1);
        add_vec(1, 24'h5, 1,  1, 24'h4, 1, 0, 0, 1);
        add_vec(1, 24'h6, 1,  1, 24'h5, 0, 0, 0, 1);
        add_vec(1, 24'h7, 1,  1, 24'h6, 0, 0, 0, 1);
        add_vec(1, 24'h8, 1,  1, 24'h7, 0, 0, 0, 1);
        add_vec(0, 24'h0, 1,  1, 24'h8, 1, 0, 0, 1);
        add_vec(0, 24'h0, 1,  0, 24'h0, 0, 0, 1, 1);
        add_vec(0, 24'h0, 1,  0, 24'h0, 0, 0, 0, 1);
        run_table("stall");

        // Two back-to-back frames at full rate: one pixel per cycle.
        apply_reset("rst2");
        run_stream("b2b", 2, 100, 100, cyc);
        check("b2b_cycles", cyc, 2 * NP + 2);

        // Mid-frame reset after pixel 3 is accepted.
        apply_reset("rst3");
        bus.m_axis_tready = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            bus.s_pix_valid = 1'b1;
            bus.s_pix_data  = 24'(k);
            @(negedge aclk);
        end
        bus.s_pix_valid = 1'b0;
        check("midrst_pre_beat", bus.m_axis_tdata, 3);
        apply_reset("midrst");
        bus.m_axis_tready = 1'b1;
        for (int k = 0; k <= 4; k++) begin
            if (k > 0) begin
                check($sformatf("midrst_beat%0d", k),
                      {bus.m_axis_tvalid, bus.m_axis_tdata, bus.m_axis_tlast, bus.m_axis_tuser},
                      {1'b1, 24'(32'h10 + k - 1), k == 4, k == 1});
            end
            bus.s_pix_valid = (k < 4);
            bus.s_pix_data  = 24'(32'h10 + k);
            @(negedge aclk);
        end

        // SOF on pixel 3 (pixel 1 carries a proper SOF too).
`ifdef SOF_CHECK_EN
        exp_user = 6'b000101;
        exp_last = 6'b100000;
        exp_err  = 6'b111100;
`else
        exp_user = 6'b000001;
        exp_last = 6'b001000;
        exp_err  = 6'b000000;
`endif
        apply_reset("rst4");
        bus.m_axis_tready = 1'b1;
        for (int k = 0; k <= 6; k++) begin
            if (k > 0) begin
                check($sformatf("sof_beat%0d", k),
                      {bus.m_axis_tvalid, bus.m_axis_tdata, bus.m_axis_tlast, bus.m_axis_tuser},
                      {1'b1, 24'(k), exp_last[k-1], exp_user[k-1]});
                check($sformatf("sof_err%0d", k), err_sof, exp_err[k-1]);
            end
            bus.s_pix_valid = (k < 6);
            bus.s_pix_data  = 24'(k + 1);
            bus.s_pix_sof   = (k == 0) || (k == 2);
            @(negedge aclk);
        end
        bus.s_pix_sof = 1'b0;

        // Random valid/ready over 1000 frames.
        apply_reset("rst5");
        run_stream("rand", 1000, 70, 60, cyc);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
